// File: rtl/bp_me_nonsynth_mem_delay_if.sv
// Handshake bundle for the memory-response delay stage.
// Inbound side is ready/valid (v_i, data_i, ready_o); outbound side is
// valid/yumi (v_o, data_o, yumi_i); occupancy_o is a monitoring tap.
// The slave modport is the delay stage itself; the master modport is
// whatever drives it (memory model upstream plus CCE buffer downstream).
interface bp_me_nonsynth_mem_delay_if #(
    parameter int width_p = 1,
    parameter int els_p   = 4
);
    localparam int occ_w_lp = $clog2(els_p + 1);

    logic                v_i;
    logic [width_p-1:0]  data_i;
    logic                ready_o;
    logic                v_o;
    logic [width_p-1:0]  data_o;
    logic                yumi_i;
    logic [occ_w_lp-1:0] occupancy_o;

    modport slave (
        input  v_i,
        input  data_i,
        input  yumi_i,
        output ready_o,
        output v_o,
        output data_o,
        output occupancy_o
    );

    modport master (
        output v_i,
        output data_i,
        output yumi_i,
        input  ready_o,
        input  v_o,
        input  data_o,
        input  occupancy_o
    );
endinterface

// File: rtl/bp_me_nonsynth_mem_delay.sv
// Latency-injection stage placed between the memory model and the CCE
// memory response buffer. Every accepted message sits in a circular buffer
// for at least latency_p cycles and leaves strictly in order.
// Optional random extra delay is compiled in with the macro
// BP_ME_NONSYNTH_MEM_DELAY_JITTER_EN: a 16-bit Fibonacci LFSR (taps
// 16,14,13,11) steps on each enqueue and its low jitter_bits_p bits are
// added to the countdown load. Without the macro the LFSR does not exist.
module bp_me_nonsynth_mem_delay #(
    parameter int          width_p       = 1,
    parameter int          els_p         = 4,
    parameter int          latency_p     = 8,
    parameter int          jitter_bits_p = 3,
    parameter logic [15:0] lfsr_seed_p   = 16'h5A
) (
    input logic clk_i,
    input logic reset_i,
    bp_me_nonsynth_mem_delay_if.slave bus
);
    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(latency_p + (1 << jitter_bits_p));
    localparam int occ_w_lp = $clog2(els_p + 1);

    localparam logic [ptr_w_lp-1:0] last_ptr_lp  = ptr_w_lp'(els_p - 1);
    localparam logic [ptr_w_lp-1:0] one_ptr_lp   = ptr_w_lp'(1);
    localparam logic [cnt_w_lp-1:0] one_cnt_lp   = cnt_w_lp'(1);
    localparam logic [cnt_w_lp-1:0] base_load_lp = cnt_w_lp'(latency_p - 1);
    localparam logic [occ_w_lp-1:0] one_occ_lp   = occ_w_lp'(1);
    localparam logic [occ_w_lp-1:0] full_occ_lp  = occ_w_lp'(els_p);

    // Parameter sanity checks, evaluated once at elaboration.
    if (latency_p < 1) begin : g_bad_latency
        $error("bp_me_nonsynth_mem_delay: latency_p must be >= 1");
    end
    if (els_p < 2) begin : g_bad_els
        $error("bp_me_nonsynth_mem_delay: els_p must be >= 2");
    end
    if (lfsr_seed_p == 16'h0) begin : g_bad_seed
        $error("bp_me_nonsynth_mem_delay: lfsr_seed_p must be nonzero");
    end
    if (jitter_bits_p < 1 || jitter_bits_p > 16) begin : g_bad_jitter
        $error("bp_me_nonsynth_mem_delay: jitter_bits_p must be 1..16");
    end

    logic [width_p-1:0]  data_q [els_p];
    logic [width_p-1:0]  data_d [els_p];
    logic [cnt_w_lp-1:0] ctr_q  [els_p];
    logic [cnt_w_lp-1:0] ctr_d  [els_p];
    logic [ptr_w_lp-1:0] rptr_q, rptr_d;
    logic [ptr_w_lp-1:0] wptr_q, wptr_d;
    logic [occ_w_lp-1:0] count_q, count_d;

    logic                ready;
    logic                v;
    logic                enq;
    logic                deq;
    logic [cnt_w_lp-1:0] load_val;

    // Handshake status depends only on registered state, so v_o and ready_o
    // never have a combinational path from v_i or data_i.
    always_comb begin
        ready = (count_q != full_occ_lp);
        v     = (count_q != '0) && (ctr_q[rptr_q] == '0);
        enq   = bus.v_i && ready;
        deq   = bus.yumi_i && v;
    end

`ifdef BP_ME_NONSYNTH_MEM_DELAY_JITTER_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Countdown load picks up the current LFSR low bits; the LFSR then steps.
    always_comb begin
        lfsr_d = lfsr_q;
        if (enq) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
        load_val = base_load_lp + cnt_w_lp'(lfsr_q[jitter_bits_p-1:0]);
    end

    // LFSR restarts from the seed on reset so runs are repeatable.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            lfsr_q <= lfsr_seed_p;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign load_val = base_load_lp;
`endif

    // Pointer and occupancy bookkeeping; a push and a pop together leave
    // the count unchanged while both pointers advance.
    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (enq) begin
            wptr_d = (wptr_q == last_ptr_lp) ? '0 : wptr_q + one_ptr_lp;
        end
        if (deq) begin
            rptr_d = (rptr_q == last_ptr_lp) ? '0 : rptr_q + one_ptr_lp;
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + one_occ_lp;
            2'b01:   count_d = count_q - one_occ_lp;
            default: count_d = count_q;
        endcase
    end

    // Every nonzero counter ticks down regardless of head blocking; empty
    // slots always hold zero so they need no separate valid qualifier.
    always_comb begin
        for (int i = 0; i < els_p; i++) begin
            ctr_d[i]  = (ctr_q[i] != '0) ? ctr_q[i] - one_cnt_lp : '0;
            data_d[i] = data_q[i];
        end
        if (enq) begin
            ctr_d[wptr_q]  = load_val;
            data_d[wptr_q] = bus.data_i;
        end
    end

    // Control state; reset drops every held message at once.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < els_p; i++) begin
                ctr_q[i] <= '0;
            end
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            ctr_q   <= ctr_d;
        end
    end

    // Payload storage needs no reset since count gates its visibility.
    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

    assign bus.ready_o     = ready;
    assign bus.v_o         = v;
    assign bus.data_o      = data_q[rptr_q];
    assign bus.occupancy_o = count_q;

    // The consumer must only take a message that is being presented.
    a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (reset_i)
        !(bus.yumi_i && !v));

endmodule

// File: tb/tb_bp_me_nonsynth_mem_delay.sv
// Bench for bp_me_nonsynth_mem_delay. Two instances: an 8-cycle stage and a
// 1-cycle stage. Accepted messages go into per-instance expectation queues;
// negedge monitors pop and compare on every v_o & yumi_i.
// Works with or without BP_ME_NONSYNTH_MEM_DELAY_JITTER_EN defined.
module tb_bp_me_nonsynth_mem_delay;
    localparam int width_lp = 8;
    localparam int els_lp   = 4;
    localparam int lat_a_lp = 8;
    localparam int lat_b_lp = 1;
    localparam int jit_lp   = 3;
`ifdef BP_ME_NONSYNTH_MEM_DELAY_JITTER_EN
    localparam int jit_on_lp = 1;
`else
    localparam int jit_on_lp = 0;
`endif
    // Hand-computed from seed 'h5A: LFSR low bits give 2, then 4, 0, 0, 0.
    localparam int first_delay_lp  = lat_a_lp + (jit_on_lp ? 2 : 0);
    localparam int second_delay_lp = lat_a_lp + (jit_on_lp ? 4 : 0);
    localparam int max_delay_lp    = lat_a_lp + (jit_on_lp ? 7 : 0);

    typedef struct {
        logic [7:0] data;
        int         edge_n;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic tie8  = 1'b0;
    logic yumi8 = 1'b0;
    logic tie1  = 1'b0;
    logic yumi1 = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;
    int   pops1  = 0;

    exp_t exp8_q[$];
    exp_t exp1_q[$];
    int   delays8[$];
    int   run1_delays[$];
    exp_t m8_e, m1_e;
    int   m8_delay, m1_delay;

    bp_me_nonsynth_mem_delay_if #(.width_p(width_lp), .els_p(els_lp)) bus8 ();
    bp_me_nonsynth_mem_delay_if #(.width_p(width_lp), .els_p(els_lp)) bus1 ();

    assign bus8.yumi_i = tie8 ? bus8.v_o : yumi8;
    assign bus1.yumi_i = tie1 ? bus1.v_o : yumi1;

    bp_me_nonsynth_mem_delay #(
        .width_p(width_lp), .els_p(els_lp), .latency_p(lat_a_lp),
        .jitter_bits_p(jit_lp), .lfsr_seed_p(16'h5A)
    ) dut8 (
        .clk_i(clk), .reset_i(reset), .bus(bus8)
    );

    bp_me_nonsynth_mem_delay #(
        .width_p(width_lp), .els_p(els_lp), .latency_p(lat_b_lp),
        .jitter_bits_p(jit_lp), .lfsr_seed_p(16'h5A)
    ) dut1 (
        .clk_i(clk), .reset_i(reset), .bus(bus1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic int occ_of(input int sel);
        return (sel == 8) ? int'(bus8.occupancy_o) : int'(bus1.occupancy_o);
    endfunction

    // Present one message and hold it until accepted; record the accept edge.
    task automatic apply_stimulus(input int sel, input logic [7:0] d);
        int  waited;
        bit  done;
        logic rdy;
        waited = 0;
        done   = 1'b0;
        if (sel == 8) begin bus8.v_i = 1'b1; bus8.data_i = d; end
        else          begin bus1.v_i = 1'b1; bus1.data_i = d; end
        while (!done && waited < 100) begin
            @(negedge clk);
            rdy = (sel == 8) ? bus8.ready_o : bus1.ready_o;
            if (rdy) begin
                if (sel == 8) exp8_q.push_back('{d, cyc + 1});
                else          exp1_q.push_back('{d, cyc + 1});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            waited++;
        end
        if (!done) check_output("accept_timeout", 32'(waited), 32'd0);
        if (sel == 8) bus8.v_i = 1'b0;
        else          bus1.v_i = 1'b0;
    endtask

    task automatic wait_empty(input int sel, input int budget, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (occ_of(sel) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output(name, 32'(occ_of(sel)), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #3;
        reset = 1'b1;
        exp8_q.delete();
        exp1_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_spaced(input int n);
        delays8.delete();
        tie8 = 1'b1;
        for (int k = 0; k < n; k++) begin
            apply_stimulus(8, 8'(8'h40 + k));
            wait_empty(8, 40, "spaced_drain");
        end
    endtask

    task automatic check_spaced_run();
        int bad;
        bad = 0;
        check_output("spaced_count", 32'(delays8.size()), 32'd50);
        if (delays8.size() >= 2) begin
            check_output("spaced_first_delay", 32'(delays8[0]), 32'(first_delay_lp));
            check_output("spaced_second_delay", 32'(delays8[1]), 32'(second_delay_lp));
        end
        foreach (delays8[i]) begin
            if (delays8[i] < lat_a_lp || delays8[i] > max_delay_lp) bad++;
        end
        check_output("spaced_out_of_window", 32'(bad), 32'd0);
    endtask

    // Scoreboard for the 8-cycle instance: order, data and minimum delay.
    always @(negedge clk) begin
        if (!reset && bus8.v_o && bus8.yumi_i) begin
            if (exp8_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL pop8_unexpected actual=data %0h required=no message pending", bus8.data_o);
            end else begin
                m8_e     = exp8_q.pop_front();
                m8_delay = cyc + 1 - m8_e.edge_n;
                check_output("pop8_data", 32'(bus8.data_o), 32'(m8_e.data));
                check_output("pop8_delay_min", 32'(m8_delay >= lat_a_lp), 32'd1);
                delays8.push_back(m8_delay);
            end
        end
    end

    // Scoreboard for the 1-cycle instance: every pop exactly one edge later.
    always @(negedge clk) begin
        if (!reset && bus1.v_o && bus1.yumi_i) begin
            if (exp1_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL pop1_unexpected actual=data %0h required=no message pending", bus1.data_o);
            end else begin
                m1_e     = exp1_q.pop_front();
                m1_delay = cyc + 1 - m1_e.edge_n;
                check_output("pop1_data", 32'(bus1.data_o), 32'(m1_e.data));
                check_output("pop1_delay", 32'(m1_delay), 32'(lat_b_lp));
                pops1++;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int start_cyc;
        int vcount;
        int a1;
        bus8.v_i = 1'b0; bus8.data_i = '0;
        bus1.v_i = 1'b0; bus1.data_i = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_output("rst8_v_o", 32'(bus8.v_o), 32'd0);
        check_output("rst8_ready", 32'(bus8.ready_o), 32'd1);
        check_output("rst8_occ", 32'(bus8.occupancy_o), 32'd0);
        check_output("rst1_v_o", 32'(bus1.v_o), 32'd0);
        check_output("rst1_ready", 32'(bus1.ready_o), 32'd1);
        check_output("rst1_occ", 32'(bus1.occupancy_o), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single message with yumi tied to v_o
        $display("[TB] single message");
        delays8.delete();
        tie8 = 1'b1;
        apply_stimulus(8, 8'hA5);
        wait_empty(8, 40, "single_drain");
        if (delays8.size() == 0) check_output("single_popped", 32'd0, 32'd1);
        else check_output("single_delay", 32'(delays8[0]), 32'(first_delay_lp));

        // Fill to full with yumi low; fifth message must be held
        $display("[TB] fill and hold");
        tie8 = 1'b0;
        yumi8 = 1'b0;
        for (int k = 0; k < 4; k++) apply_stimulus(8, 8'(8'h10 + k));
        check_output("full_ready", 32'(bus8.ready_o), 32'd0);
        check_output("full_occ", 32'(bus8.occupancy_o), 32'd4);
        check_output("full_v_o_early", 32'(bus8.v_o), 32'd0);
        a1 = exp8_q[0].edge_n;
        bus8.v_i = 1'b1;
        bus8.data_i = 8'h14;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_output("held_ready", 32'(bus8.ready_o), 32'd0);
            check_output("held_occ", 32'(bus8.occupancy_o), 32'd4);
        end
        vcount = 0;
        while (!bus8.v_o && vcount < 40) begin
            @(negedge clk);
            vcount++;
        end
        check_output("first_mature_edge", 32'(cyc), 32'(a1 + lat_a_lp - 1 + (jit_on_lp ? 4 : 0)));

        // Full with everything matured: yumi and v_i together only dequeue
        $display("[TB] full dequeue without bypass");
        repeat (30) @(posedge clk);
        #1;
        yumi8 = 1'b1;
        @(negedge clk);
        check_output("bypass_ready", 32'(bus8.ready_o), 32'd0);
        check_output("bypass_v_o", 32'(bus8.v_o), 32'd1);
        @(posedge clk);
        #1;
        yumi8 = 1'b0;
        check_output("after_pop_ready", 32'(bus8.ready_o), 32'd1);
        check_output("after_pop_occ", 32'(bus8.occupancy_o), 32'd3);
        apply_stimulus(8, 8'h14);
        check_output("pending_accepted_occ", 32'(bus8.occupancy_o), 32'd4);
        tie8 = 1'b1;
        wait_empty(8, 80, "full_drain");

        // One-cycle stage streaming 100 messages
        $display("[TB] latency 1 streaming");
        tie1 = 1'b1;
        start_cyc = cyc;
        for (int k = 0; k < 100; k++) apply_stimulus(1, 8'(k * 7 + 3));
        check_output("stream_cycles", 32'(cyc - start_cyc), 32'd100);
        wait_empty(1, 10, "stream_drain");
        check_output("stream_pops", 32'(pops1), 32'd100);

        // Asynchronous reset with three messages held
        $display("[TB] mid-cycle reset");
        tie8 = 1'b0;
        yumi8 = 1'b0;
        for (int k = 0; k < 3; k++) apply_stimulus(8, 8'(8'hC0 + k));
        check_output("prereset_occ", 32'(bus8.occupancy_o), 32'd3);
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_output("async_v_o", 32'(bus8.v_o), 32'd0);
        check_output("async_ready", 32'(bus8.ready_o), 32'd1);
        check_output("async_occ", 32'(bus8.occupancy_o), 32'd0);
        exp8_q.delete();
        exp1_q.delete();
        @(negedge clk);
        check_output("in_reset_v_o", 32'(bus8.v_o), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tie8 = 1'b1;
        vcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus8.v_o) vcount++;
        end
        check_output("postreset_no_emit", 32'(vcount), 32'd0);
        check_output("postreset_occ", 32'(bus8.occupancy_o), 32'd0);
        @(posedge clk);
        #1;

        // Spaced messages, twice from reset: delays in window and repeatable
        $display("[TB] spaced delay runs");
        run_spaced(50);
        check_spaced_run();
        run1_delays = delays8;
        reset_pulse();
        run_spaced(50);
        check_spaced_run();
        vcount = 0;
        foreach (delays8[i]) begin
            if (i >= run1_delays.size() || delays8[i] != run1_delays[i]) vcount++;
        end
        check_output("repeat_run_diffs", 32'(vcount), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bp_me_nonsynth_mem_delay.md
Name: bp_me_nonsynth_mem_delay

Overview:
- Nonsynthesizable latency-injection stage between the memory model's response output and the CCE memory response buffer in the CCE unit testbench.
- Accepts memory response messages on a ready/valid port and holds each one for a programmable minimum number of cycles.
- Releases messages in order on a valid/yumi port.
- Stresses CCE speculative-access and writeback ordering under long or variable memory latency, without changing the memory model itself.

Parameters:
- width_p, 1, message width in bits; set to the bit width of the CCE memory message struct.
- els_p, 4, number of buffer entries; must be >= 2.
- latency_p, 8, minimum cycles from acceptance to v_o for an entry; must be >= 1.
- jitter_bits_p, 3, width of the random extra delay; used only when the optional feature is compiled in.
- lfsr_seed_p, 'h5A, nonzero seed for the jitter LFSR.

Ports:
- clk_i  input  1  clock; all state updates on posedge.
- reset_i  input  1  asynchronous, active-high reset.
- v_i  input  1  inbound message valid.
- data_i  input  width_p  inbound message.
- ready_o  output  1  buffer can accept a message this cycle.
- v_o  output  1  head message has matured and is presented.
- data_o  output  width_p  head message.
- yumi_i  input  1  consumer takes the head message; legal only when v_o=1.
- occupancy_o  output  clog2(els_p+1)  number of valid entries, for bench monitoring.

Behaviour:
- Decided interface facts: one clock (clk_i); reset is asynchronous and active-high (reset_i).
- Storage: circular buffer of els_p entries, with read pointer, write pointer and count. Each entry holds data and a delay counter of width clog2(latency_p + 2^jitter_bits_p).
- Enqueue: occurs when v_i & ready_o at posedge. The entry is written at the write pointer, its counter is loaded with latency_p-1, and the write pointer advances with wrap from els_p-1 to 0.
- Countdown: every cycle, every valid entry with counter > 0 decrements by 1. Counters saturate at 0. Non-head entries keep counting while the head is blocked.
- Release:
  - v_o = (count != 0) & (head counter == 0).
  - data_o = head data whenever count != 0, otherwise don't-care (bench must not check it).
  - v_o is combinational from registered state only; no combinational path from v_i or data_i.
- Dequeue: yumi_i at posedge pops the head and advances the read pointer with wrap.
- Latency: an entry accepted at edge N raises v_o in the cycle following edge N+latency_p-1. With latency_p=1, the block behaves like a 1-cycle FIFO.
- Ordering: strictly in order. A matured younger entry never bypasses an immature head.
- Full: ready_o = (count != els_p). When full, ready_o=0 even if yumi_i is asserted the same cycle; there is no enqueue-on-dequeue bypass at full.
- Empty: v_o=0. A message enqueued into an empty buffer still waits the full latency.
- Simultaneous enqueue and dequeue when not full: count is unchanged and both pointers advance.
- Reset values: count=0, both pointers=0, all counters=0, v_o=0, ready_o=1, occupancy_o=0, LFSR=lfsr_seed_p.
- Reset asserted mid-operation: all held messages are discarded immediately and asynchronously. No output glitches to v_o=1 during reset.
- Assertions (nonsynth, disabled while reset_i=1):
  - yumi_i & ~v_o is an error.
  - v_i & ~ready_o is allowed; the message is held upstream and is not an error.
  - Parameter checks at elaboration: latency_p>=1, els_p>=2.

Optional Feature:
- Macro: BP_ME_NONSYNTH_MEM_DELAY_JITTER_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) steps on every enqueue.
  - The enqueue counter load becomes latency_p-1 + lfsr[jitter_bits_p-1:0], so extra delay is 0 to 2^jitter_bits_p-1 cycles.
  - Ordering rules are unchanged.
  - The sequence is deterministic for a given lfsr_seed_p.
- Not defined: the LFSR is absent, every entry uses exactly latency_p-1, and jitter_bits_p and lfsr_seed_p are ignored.

Test Plan:
1. latency_p=8, single message 'hA5 enqueued at cycle 10, yumi_i tied to v_o -> v_o first high at cycle 18 with data_o='hA5; occupancy_o returns to 0 at cycle 19.
2. els_p=4, latency_p=8, five back-to-back v_i with yumi_i=0 -> four accepted, ready_o=0 from the cycle after the fourth accept, fifth held; v_o high only after the first entry matures.
3. Full buffer, all entries matured, yumi_i=1 and v_i=1 in the same cycle -> only the dequeue happens; ready_o=1 the next cycle; the pending message is accepted then.
4. latency_p=1, continuous v_i with yumi_i=v_o -> one message per cycle throughput; output order matches input order for a 100-message sequence.
5. Reset pulsed asynchronously mid-cycle with 3 entries held -> v_o=0, ready_o=1, occupancy_o=0 immediately; held messages are never emitted after reset.
6. Jitter macro defined, jitter_bits_p=3, 50 messages -> every delay is in 8..15 cycles; output order matches input order; two runs with the same seed produce identical timing.
